// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: bus command codes, requester ownership and arbiter states shared by the memory arbiter slice.
package mem_bus_arbiter_pkg;
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_e;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD_DC = 2'd1, HOLD_IC = 2'd2} arb_state_e;
endpackage

// File: rtl/mem_tag_owner_table.sv
// mem_tag_owner_table: per-tag valid/owner record of outstanding loads with retire lookup and sticky error.
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TAG_BITS = 4,
  parameter int NUM_TAGS = 1 << TAG_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                alloc_en,
  input  logic [TAG_BITS-1:0] alloc_tag,
  input  owner_e              alloc_owner,
  input  logic [TAG_BITS-1:0] ret_tag,
  output logic                ret_hit,
  output owner_e              ret_owner,
  output logic                tag_error
);
  logic [NUM_TAGS-1:0] valid;
  logic [NUM_TAGS-1:0] own_dc;
  logic ret_miss;
  logic clash;
  always_comb begin
    ret_hit   = ret_tag != '0 && valid[ret_tag];
    ret_miss  = ret_tag != '0 && !valid[ret_tag];
    ret_owner = own_dc[ret_tag] ? OWN_DC : OWN_IC;
    clash     = alloc_en && valid[alloc_tag] && !(ret_hit && ret_tag == alloc_tag);
  end
  // Allocation is written after retirement so a same-cycle reuse of a tag keeps the new owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid     <= '0;
      own_dc    <= '0;
      tag_error <= 1'b0;
    end else begin
      if (ret_hit) valid[ret_tag] <= 1'b0;
      if (alloc_en) begin
        valid[alloc_tag]  <= 1'b1;
        own_dc[alloc_tag] <= alloc_owner == OWN_DC;
      end
      if (ret_miss || clash) tag_error <= 1'b1;
    end
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the tagged memory port between IC and DC with DC priority, IC anti-starvation and tag-based return steering.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TAG_BITS = 4,
  parameter int NUM_TAGS = 1 << TAG_BITS,
  parameter int MAX_WAIT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          dc_command,
  input  logic [63:0]         dc_addr,
  input  logic [63:0]         dc_data,
  input  logic [1:0]          ic_command,
  input  logic [63:0]         ic_addr,
  input  logic [TAG_BITS-1:0] mem_response,
  input  logic [TAG_BITS-1:0] mem_tag,
  input  logic [63:0]         mem_data,
  output logic [1:0]          proc2mem_command,
  output logic [63:0]         proc2mem_addr,
  output logic [63:0]         proc2mem_data,
  output logic [TAG_BITS-1:0] dc_response,
  output logic [TAG_BITS-1:0] ic_response,
  output logic [TAG_BITS-1:0] dc_tag,
  output logic [TAG_BITS-1:0] ic_tag,
  output logic [63:0]         rsp_data,
  output logic [4:0]          dc_outstanding,
  output logic [4:0]          ic_outstanding,
  output logic                tag_error
);
  localparam int SW = $clog2(MAX_WAIT + 1);
  arb_state_e state, state_nx;
  logic [SW-1:0] starve_cnt, starve_nx;
  logic dc_req, ic_req, ic_first, grant_dc, grant_ic, accepted, alloc_en, ret_hit;
  owner_e alloc_owner, ret_owner;
  // Grants are gated by reset so every combinational output reads 0 while reset is held.
  always_comb begin
    dc_req           = dc_command != BUS_NONE;
    ic_req           = ic_command == BUS_LOAD;
    ic_first         = ic_req && starve_cnt == SW'(MAX_WAIT);
    grant_dc         = !reset && (state == HOLD_DC ? dc_req : state == IDLE && dc_req && !ic_first);
    grant_ic         = !reset && (state == HOLD_IC ? ic_req : state == IDLE && ic_req && (ic_first || !dc_req));
    accepted         = mem_response != '0;
    state_nx         = grant_dc && !accepted ? HOLD_DC : grant_ic && !accepted ? HOLD_IC : IDLE;
    starve_nx        = !ic_req || (grant_ic && accepted) ? '0 :
                       grant_ic || starve_cnt == SW'(MAX_WAIT) ? starve_cnt : starve_cnt + 1'b1;
    alloc_en         = accepted && (grant_ic || (grant_dc && dc_command == BUS_LOAD));
    alloc_owner      = grant_dc ? OWN_DC : OWN_IC;
    proc2mem_command = grant_dc ? dc_command : grant_ic ? ic_command : BUS_NONE;
    proc2mem_addr    = grant_dc ? dc_addr : grant_ic ? ic_addr : '0;
    proc2mem_data    = grant_dc ? dc_data : '0;
    dc_response      = grant_dc ? mem_response : '0;
    ic_response      = grant_ic ? mem_response : '0;
    dc_tag           = !reset && ret_hit && ret_owner == OWN_DC ? mem_tag : '0;
    ic_tag           = !reset && ret_hit && ret_owner == OWN_IC ? mem_tag : '0;
    rsp_data         = reset ? '0 : mem_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      dc_outstanding <= '0;
      ic_outstanding <= '0;
    end else begin
      state          <= state_nx;
      starve_cnt     <= starve_nx;
      dc_outstanding <= dc_outstanding + 5'(alloc_en && alloc_owner == OWN_DC) - 5'(ret_hit && ret_owner == OWN_DC);
      ic_outstanding <= ic_outstanding + 5'(alloc_en && alloc_owner == OWN_IC) - 5'(ret_hit && ret_owner == OWN_IC);
    end
  end
  mem_tag_owner_table #(.TAG_BITS(TAG_BITS), .NUM_TAGS(NUM_TAGS)) u_owner (
    .clock      (clock),
    .reset      (reset),
    .alloc_en   (alloc_en),
    .alloc_tag  (mem_response),
    .alloc_owner(alloc_owner),
    .ret_tag    (mem_tag),
    .ret_hit    (ret_hit),
    .ret_owner  (ret_owner),
    .tag_error  (tag_error)
  );
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench; a transaction-level model predicts each cycle and a negedge monitor compares.
module tb_mem_bus_arbiter;
  localparam int MAX_WAIT = 8;
  localparam logic [1:0] N = 2'd0, L = 2'd1, S = 2'd2;
  logic clock = 1'b0;
  logic reset;
  logic [1:0] dc_command, ic_command, proc2mem_command;
  logic [63:0] dc_addr, dc_data, ic_addr, mem_data, proc2mem_addr, proc2mem_data, rsp_data;
  logic [3:0] mem_response, mem_tag, dc_response, ic_response, dc_tag, ic_tag;
  logic [4:0] dc_outstanding, ic_outstanding;
  logic tag_error;
  always #5 clock = ~clock;
  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .dc_command(dc_command), .dc_addr(dc_addr), .dc_data(dc_data),
    .ic_command(ic_command), .ic_addr(ic_addr),
    .mem_response(mem_response), .mem_tag(mem_tag), .mem_data(mem_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .dc_response(dc_response), .ic_response(ic_response),
    .dc_tag(dc_tag), .ic_tag(ic_tag), .rsp_data(rsp_data),
    .dc_outstanding(dc_outstanding), .ic_outstanding(ic_outstanding), .tag_error(tag_error)
  );
  typedef struct {
    logic [1:0]  cmd;
    logic [63:0] addr, data, rdata;
    logic [3:0]  dresp, iresp, dtag, itag;
    logic [4:0]  dout, iout;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_chk = 0, n_pass = 0;
  int m_hold, m_starve, m_dc_out, m_ic_out;
  bit m_err;
  bit m_valid[16];
  bit m_dc_own[16];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // Reference model: owner map per tag, counters as plain integers, "held" requester.
  task automatic cycle(input logic rst, input logic [1:0] dcc, input logic [63:0] dca, input logic [63:0] dcd,
                       input logic [1:0] icc, input logic [63:0] ica, input logic [3:0] resp, input logic [3:0] tg);
    exp_t e;
    int w;
    bit dreq, ireq;
    logic [63:0] md;
    @(posedge clock);
    #1;
    md = {$urandom, $urandom};
    reset = rst; dc_command = dcc; dc_addr = dca; dc_data = dcd;
    ic_command = icc; ic_addr = ica; mem_response = resp; mem_tag = tg; mem_data = md;
    e = '{default: '0};
    e.dout = 5'(m_dc_out);
    e.iout = 5'(m_ic_out);
    e.err = m_err;
    if (rst) begin
      m_hold = 0; m_starve = 0; m_dc_out = 0; m_ic_out = 0; m_err = 0;
      foreach (m_valid[i]) m_valid[i] = 0;
    end else begin
      dreq = dcc != N;
      ireq = icc == L;
      if (m_hold == 1) w = dreq ? 1 : 0;
      else if (m_hold == 2) w = ireq ? 2 : 0;
      else if (ireq && m_starve >= MAX_WAIT) w = 2;
      else if (dreq) w = 1;
      else if (ireq) w = 2;
      else w = 0;
      e.cmd = w == 1 ? dcc : w == 2 ? icc : N;
      e.addr = w == 1 ? dca : w == 2 ? ica : 64'd0;
      e.data = w == 1 ? dcd : 64'd0;
      e.dresp = w == 1 ? resp : 4'd0;
      e.iresp = w == 2 ? resp : 4'd0;
      e.rdata = md;
      if (tg != 0) begin
        if (m_valid[tg]) begin
          m_valid[tg] = 0;
          if (m_dc_own[tg]) begin e.dtag = tg; m_dc_out--; end
          else begin e.itag = tg; m_ic_out--; end
        end else m_err = 1;
      end
      if (w != 0 && resp != 0 && e.cmd == L) begin
        if (m_valid[resp]) m_err = 1;
        m_valid[resp] = 1;
        m_dc_own[resp] = w == 1;
        if (w == 1) m_dc_out++; else m_ic_out++;
      end
      if (!ireq || (w == 2 && resp != 0)) m_starve = 0;
      else if (w != 2 && m_starve < MAX_WAIT) m_starve++;
      m_hold = (w != 0 && resp == 0) ? w : 0;
    end
    sb.push_back(e);
  endtask
  initial forever begin
    @(negedge clock);
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("proc2mem_command", 64'(proc2mem_command), 64'(mon_e.cmd));
      chk("proc2mem_addr", proc2mem_addr, mon_e.addr);
      chk("proc2mem_data", proc2mem_data, mon_e.data);
      chk("dc_response", 64'(dc_response), 64'(mon_e.dresp));
      chk("ic_response", 64'(ic_response), 64'(mon_e.iresp));
      chk("dc_tag", 64'(dc_tag), 64'(mon_e.dtag));
      chk("ic_tag", 64'(ic_tag), 64'(mon_e.itag));
      chk("rsp_data", rsp_data, mon_e.rdata);
      chk("dc_outstanding", 64'(dc_outstanding), 64'(mon_e.dout));
      chk("ic_outstanding", 64'(ic_outstanding), 64'(mon_e.iout));
      chk("tag_error", 64'(tag_error), 64'(mon_e.err));
    end
  end
  initial begin
    int valid_q[$];
    logic rst;
    logic [1:0] dcc, icc;
    logic [3:0] resp, tg;
    reset = 1'b1; dc_command = N; dc_addr = '0; dc_data = '0; ic_command = N; ic_addr = '0;
    mem_response = '0; mem_tag = '0; mem_data = '0;
    @(posedge clock);
    cycle(1, L, 64'h100, 0, L, 64'h200, 4'd3, 4'd0);
    // DC priority on a simultaneous request, then return of tag 3 to DC
    cycle(0, L, 64'h100, 0, L, 64'h200, 4'd3, 4'd0);
    cycle(0, N, 0, 0, N, 0, 4'd0, 4'd0);
    cycle(0, N, 0, 0, N, 0, 4'd0, 4'd3);
    // IC held against a later DC request until accepted with tag 5
    cycle(0, N, 0, 0, L, 64'h200, 4'd0, 4'd0);
    for (int k = 0; k < 3; k++) cycle(0, L, 64'h300, 0, L, 64'h200, 4'd0, 4'd0);
    cycle(0, L, 64'h300, 0, L, 64'h200, 4'd5, 4'd0);
    cycle(0, L, 64'h300, 0, N, 0, 4'd6, 4'd0);
    cycle(0, N, 0, 0, N, 0, 4'd0, 4'd5);
    cycle(0, N, 0, 0, N, 0, 4'd0, 4'd6);
    // Starvation override: IC wins on the ninth contested cycle
    cycle(1, N, 0, 0, N, 0, 4'd0, 4'd0);
    for (int k = 0; k < 12; k++) cycle(0, S, 64'h400 + 64'(k), 64'(k), L, 64'h500, 4'd9, 4'd0);
    cycle(0, N, 0, 0, N, 0, 4'd0, 4'd9);
    // Store accept allocates nothing, so its tag return is an error
    cycle(0, S, 64'h600, 64'h77, N, 0, 4'd7, 4'd0);
    cycle(0, N, 0, 0, N, 0, 4'd0, 4'd7);
    // Same-cycle retire of IC tag 2 and reallocation to DC
    cycle(1, N, 0, 0, N, 0, 4'd0, 4'd0);
    cycle(0, N, 0, 0, L, 64'h700, 4'd2, 4'd0);
    cycle(0, L, 64'h800, 0, N, 0, 4'd2, 4'd2);
    cycle(0, N, 0, 0, N, 0, 4'd0, 4'd2);
    // Reset with loads in flight discards ownership
    cycle(0, L, 64'h900, 0, N, 0, 4'd1, 4'd0);
    cycle(0, N, 0, 0, L, 64'h980, 4'd4, 4'd0);
    cycle(0, L, 64'h990, 0, N, 0, 4'd8, 4'd0);
    cycle(1, N, 0, 0, N, 0, 4'd0, 4'd0);
    cycle(0, N, 0, 0, N, 0, 4'd0, 4'd1);
    cycle(0, N, 0, 0, N, 0, 4'd0, 4'd0);
    for (int k = 0; k < 600; k++) begin
      rst = $urandom_range(0, 79) == 0;
      dcc = $urandom_range(0, 3) == 0 ? N : 2'($urandom_range(1, 2));
      icc = $urandom_range(0, 1) == 0 ? N : L;
      resp = $urandom_range(0, 1) == 0 ? 4'd0 : 4'($urandom_range(1, 15));
      valid_q.delete();
      foreach (m_valid[i]) if (m_valid[i]) valid_q.push_back(i);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: tg = valid_q.size() > 0 ? 4'(valid_q[$urandom_range(0, valid_q.size() - 1)]) : 4'd0;
        4: tg = 4'($urandom_range(1, 15));
        default: tg = 4'd0;
      endcase
      cycle(rst, dcc, {$urandom, $urandom}, {$urandom, $urandom}, icc, {$urandom, $urandom}, resp, tg);
    end
    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
